// File: rtl/trig_period.sv
// Hysteresis trigger plus averaged period counter for the sample stream.
// Build option: define TRIG_PERIOD_HYST_EN to enable the vpp/8 hysteresis band.
module trig_period #(
    parameter int          DATA_BIT_WIDTH = 12,
    parameter int          LOG2_PERIODS   = 2,
    parameter int unsigned TIMEOUT        = 4096
) (
    input  logic                      clk_fs,
    input  logic                      rst,
    input  logic [DATA_BIT_WIDTH-1:0] data_u,
    input  logic [DATA_BIT_WIDTH-1:0] max,
    input  logic [DATA_BIT_WIDTH-1:0] min,
    input  logic [DATA_BIT_WIDTH-1:0] vpp,
    input  logic                      lvl_upd,
    output logic                      sq,
    output logic [31:0]               period,
    output logic                      period_vld,
    output logic                      timeout,
    output logic [1:0]                dbg_state
);

    localparam int W  = DATA_BIT_WIDTH;
    localparam int EW = LOG2_PERIODS + 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'((2 ** LOG2_PERIODS) - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, MEAS = 2'd2} state_t;

    state_t        state_q, state_d;
    logic          lvl_q;
    logic [W-1:0]  th_hi, th_lo, th_hi_n, th_lo_n, mid;
    logic [W:0]    sum_w;
    logic          sq_q, sq_d;
    logic [31:0]   cnt, cnt_d, cnt_inc, period_d;
    logic [EW-1:0] edge_cnt, edge_d;
    logic          vld_d, tmo_d;
    logic          lvl_load, lvl_ok, rise;

    assign sum_w = {1'b0, max} + {1'b0, min};
    assign mid   = W'(sum_w >> 1);

`ifdef TRIG_PERIOD_HYST_EN
    logic [W-1:0] hyst;
    logic [W:0]   hi_w;
    assign hyst    = vpp >> 3;
    assign hi_w    = {1'b0, mid} + {1'b0, hyst};
    assign th_hi_n = hi_w[W] ? '1 : hi_w[W-1:0];
    assign th_lo_n = (mid > hyst) ? (mid - hyst) : '0;
`else
    logic unused_vpp;
    assign unused_vpp = ^vpp;
    assign th_hi_n    = mid;
    assign th_lo_n    = mid;
`endif

    assign lvl_load  = lvl_upd & ~lvl_q;
    assign lvl_ok    = max > min;
    assign rise      = sq & ~sq_q;
    assign cnt_inc   = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    assign dbg_state = state_q;

    // period_vld is a valid-only pulse (no ready); period and timeout hold until the next pulse.
    always_comb begin
        state_d  = state_q;
        sq_d     = sq;
        cnt_d    = cnt;
        edge_d   = edge_cnt;
        period_d = period;
        vld_d    = 1'b0;
        tmo_d    = timeout;

        if (data_u > th_hi) begin
            sq_d = 1'b1;
        end else if (data_u < th_lo) begin
            sq_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                sq_d   = 1'b0;
                cnt_d  = '0;
                edge_d = '0;
            end
            ARM: begin
                if (rise) begin
                    cnt_d   = 32'd1;
                    edge_d  = '0;
                    state_d = MEAS;
                end else if (cnt >= TIMEOUT) begin
                    period_d = '0;
                    tmo_d    = 1'b1;
                    vld_d    = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            MEAS: begin
                // A completed result wins over a simultaneous timeout.
                if (rise && edge_cnt == LAST_EDGE) begin
                    period_d = cnt >> LOG2_PERIODS;
                    vld_d    = 1'b1;
                    tmo_d    = 1'b0;
                    cnt_d    = 32'd1;
                    edge_d   = '0;
                end else if (cnt >= TIMEOUT) begin
                    period_d = '0;
                    tmo_d    = 1'b1;
                    vld_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = ARM;
                end else begin
                    cnt_d = cnt_inc;
                    if (rise) edge_d = edge_cnt + EW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Degenerate levels (flat signal) invalidate everything in flight.
        if (lvl_load) begin
            if (!lvl_ok) begin
                state_d = IDLE;
                sq_d    = 1'b0;
                cnt_d   = '0;
                edge_d  = '0;
                vld_d   = 1'b0;
            end else if (state_q == IDLE) begin
                state_d = ARM;
            end
        end
    end

    always_ff @(posedge clk_fs) begin
        if (rst) begin
            state_q    <= IDLE;
            lvl_q      <= 1'b0;
            th_hi      <= '0;
            th_lo      <= '0;
            sq         <= 1'b0;
            sq_q       <= 1'b0;
            cnt        <= '0;
            edge_cnt   <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lvl_q      <= lvl_upd;
            sq         <= sq_d;
            sq_q       <= sq;
            cnt        <= cnt_d;
            edge_cnt   <= edge_d;
            period     <= period_d;
            period_vld <= vld_d;
            timeout    <= tmo_d;
            if (lvl_load) begin
                th_hi <= th_hi_n;
                th_lo <= th_lo_n;
            end
        end
    end

endmodule

// File: tb/tb_trig_period.sv
// Self-checking bench for trig_period: scoreboard of expected {timeout, period} results.
// Honours TRIG_PERIOD_HYST_EN the same way as the design.
module tb_trig_period;

    logic        clk_fs = 1'b0;
    logic        rst;
    logic [11:0] data_u, mx, mn, vpp;
    logic        lvl_upd;
    logic        sq, period_vld, timeout;
    logic [31:0] period;
    logic [1:0]  dbg_state;

    logic [32:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc = 0;
    int          last_vld_cyc = 0;
    int          last_gap = 0;
    int          rise_cnt = 0;
    logic        sq_prev = 1'b0;
    logic        ignore_vld = 1'b0;
    int          ph = 0;

    trig_period dut (
        .clk_fs(clk_fs), .rst(rst), .data_u(data_u), .max(mx), .min(mn), .vpp(vpp),
        .lvl_upd(lvl_upd), .sq(sq), .period(period), .period_vld(period_vld),
        .timeout(timeout), .dbg_state(dbg_state)
    );

    always #5 clk_fs = ~clk_fs;
    always @(posedge clk_fs) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Result monitor: every period_vld must match the head of the expected queue.
    always @(negedge clk_fs) begin
        logic [32:0] e;
        if (!rst && period_vld === 1'b1 && !ignore_vld) begin
            if (exp_q.size() == 0) begin
                check("unexpected_vld", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("period", period, e[31:0]);
                check("timeout_flag", timeout, e[32]);
            end
            last_gap     = cyc - last_vld_cyc;
            last_vld_cyc = cyc;
        end
        if (sq === 1'b1 && sq_prev === 1'b0) rise_cnt = rise_cnt + 1;
        sq_prev = sq;
    end

    function automatic int th_hi_f(input int a, input int b, input int v);
        int m, h;
        m = (a + b) / 2;
`ifdef TRIG_PERIOD_HYST_EN
        h = v / 8;
`else
        h = 0 * v;
`endif
        return (m + h > 4095) ? 4095 : m + h;
    endfunction

    function automatic int th_lo_f(input int a, input int b, input int v);
        int m, h;
        m = (a + b) / 2;
`ifdef TRIG_PERIOD_HYST_EN
        h = v / 8;
`else
        h = 0 * v;
`endif
        return (m > h) ? m - h : 0;
    endfunction

    // 0: clean square period 100; 1: constant 3000; 2: period-50 square with chatter at crossings
    function automatic logic [11:0] wave(input int mode, input int p);
        int idx;
        if (mode == 0) return (p % 100 < 50) ? 12'd4000 : 12'd0;
        if (mode == 1) return 12'd3000;
        idx = p % 50;
        if (idx <= 20) return 12'd4000;
        if (idx >= 25 && idx <= 45) return 12'd0;
        if (idx == 21 || idx == 23 || idx == 47 || idx == 49) return 12'($urandom_range(2199, 2001));
        return 12'($urandom_range(1999, 1801));
    endfunction

    task automatic drive_one(input int mode);
        data_u = wave(mode, ph);
        ph++;
        @(posedge clk_fs);
        #1;
    endtask

    task automatic drive_cycles(input int mode, input int n);
        for (int k = 0; k < n; k++) drive_one(mode);
    endtask

    task automatic run_until_drained(input int mode, input int budget, input string tag);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) drive_one(mode);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic lvl_load(input int a, input int b, input int v);
        mx = 12'(a); mn = 12'(b); vpp = 12'(v);
        lvl_upd = 1'b1;
        @(posedge clk_fs); #1;
        lvl_upd = 1'b0;
        @(posedge clk_fs); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk_fs); #1;
        rst = 1'b0;
    endtask

    initial begin
        int   seq_a[8];
        int   seq_b[6];
        int   hi, lo, c0, r0;
        logic sq_m;
        seq_a = '{2600, 1800, 1400, 2200, 2400, 3000, 1600, 1000};
        seq_b = '{3000, 4095, 3700, 3690, 3950, 3940};

        // Reset and idle
        rst = 1'b1; data_u = '0; mx = '0; mn = '0; vpp = '0; lvl_upd = 1'b0;
        repeat (2) @(posedge clk_fs);
        #1;
        check("rst_sq", sq, 0);
        check("rst_period", period, 0);
        check("rst_vld", period_vld, 0);
        check("rst_timeout", timeout, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        drive_cycles(0, 300);
        check("idle_sq", sq, 0);
        check("idle_state", dbg_state, 0);

        // Clean square, period 100
        data_u = '0;
        lvl_load(4000, 0, 4000);
        check("armed_state", dbg_state, 1);
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 32'd100});
        run_until_drained(0, 2000, "drain_sq100");
        check("vld_gap", last_gap, 400);
        check("meas_state", dbg_state, 2);

        // Flat level load during measurement
        lvl_load(1000, 1000, 0);
        check("flat_state", dbg_state, 0);
        check("flat_sq", sq, 0);
        drive_cycles(0, 10000);
        check("flat_sq_after", sq, 0);
        check("flat_state_after", dbg_state, 0);

        // Threshold behaviour, including the saturating upper threshold
        data_u = '0;
        lvl_load(4000, 0, 4000);
        hi = th_hi_f(4000, 0, 4000); lo = th_lo_f(4000, 0, 4000); sq_m = 1'b0;
        foreach (seq_a[i]) begin
            data_u = 12'(seq_a[i]);
            @(posedge clk_fs); #1;
            if (seq_a[i] > hi) sq_m = 1'b1; else if (seq_a[i] < lo) sq_m = 1'b0;
            check("sq_thr_a", sq, sq_m);
        end
        lvl_load(1000, 1000, 0);
        data_u = '0;
        lvl_load(4095, 3800, 2000);
        hi = th_hi_f(4095, 3800, 2000); lo = th_lo_f(4095, 3800, 2000); sq_m = 1'b0;
        foreach (seq_b[i]) begin
            data_u = 12'(seq_b[i]);
            @(posedge clk_fs); #1;
            if (seq_b[i] > hi) sq_m = 1'b1; else if (seq_b[i] < lo) sq_m = 1'b0;
            check("sq_thr_b", sq, sq_m);
        end

        // Timeout with a held input, then recovery
        lvl_load(1000, 1000, 0);
        data_u = '0;
        lvl_load(4000, 0, 4000);
        c0 = cyc;
        exp_q.push_back({1'b1, 32'd0});
        run_until_drained(1, 5000, "drain_tmo");
        check("tmo_time", (cyc - c0 >= 4090) && (cyc - c0 <= 4110), 1);
        check("tmo_sticky", timeout, 1);
        check("tmo_state", dbg_state, 1);
        ph = 0;
        exp_q.push_back({1'b0, 32'd100});
        run_until_drained(0, 1500, "drain_after_tmo");
        check("tmo_cleared", timeout, 0);

        // Reset mid-measurement discards partial counts
        drive_cycles(0, 150);
        pulse_reset();
        check("mid_rst_state", dbg_state, 0);
        check("mid_rst_period", period, 0);
        check("mid_rst_timeout", timeout, 0);
        check("mid_rst_sq", sq, 0);
        drive_cycles(0, 900);
        data_u = '0;
        lvl_load(4000, 0, 4000);
        exp_q.push_back({1'b0, 32'd100});
        run_until_drained(0, 1500, "drain_after_rst");

        // Chatter at the crossings
        lvl_load(1000, 1000, 0);
        data_u = '0;
        lvl_load(4000, 0, 4000);
        ph = 0;
`ifdef TRIG_PERIOD_HYST_EN
        exp_q.push_back({1'b0, 32'd50});
        exp_q.push_back({1'b0, 32'd50});
        run_until_drained(2, 800, "drain_noise");
`else
        ignore_vld = 1'b1;
        drive_cycles(2, 120);
`endif
        ignore_vld = 1'b1;
        while (ph % 50 != 10) drive_one(2);
        r0 = rise_cnt;
        drive_cycles(2, 400);
`ifdef TRIG_PERIOD_HYST_EN
        check("noise_rises", rise_cnt - r0, 8);
`else
        check("noise_rises", rise_cnt - r0, 24);
`endif
        lvl_load(1000, 1000, 0);
        ignore_vld = 1'b0;
        drive_cycles(0, 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trig_period.md
TRIG_PERIOD -- requirements
Module: trig_period

Interface
REQ-001 Parameter DATA_BIT_WIDTH, default 12: width of sample and level inputs.
REQ-002 Parameter LOG2_PERIODS, default 2: periods averaged per result = 2^LOG2_PERIODS.
REQ-003 Parameter TIMEOUT, default 4096: samples without a completed result before timeout; range 2..2^32-1.
REQ-004 clk_fs  in  1  sample clock; one sample per rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 data_u  in  DATA_BIT_WIDTH  unsigned sample.
REQ-007 max  in  DATA_BIT_WIDTH  window maximum from the peak-to-peak stage.
REQ-008 min  in  DATA_BIT_WIDTH  window minimum from the peak-to-peak stage.
REQ-009 vpp  in  DATA_BIT_WIDTH  window peak-to-peak from the peak-to-peak stage.
REQ-010 lvl_upd  in  1  level-update strobe; the peak-to-peak stage's irq; only its 0->1 edge acts.
REQ-011 sq  out  1  hysteresis-comparator output (squared signal).
REQ-012 period  out  32  averaged period in samples; 0 on timeout.
REQ-013 period_vld  out  1  one-cycle pulse when period is updated.
REQ-014 timeout  out  1  sticky flag: last result was a timeout.

Function
REQ-015 lvl_upd edge detected against a registered copy; on the edge, thresholds SHALL load next cycle: mid=(max+min)>>1 computed in DATA_BIT_WIDTH+1 bits, hyst=vpp>>3, th_hi=min(mid+hyst, 2^DATA_BIT_WIDTH-1), th_lo=max(mid-hyst, 0).
REQ-016 States SHALL be IDLE (no valid levels), ARM (waiting for first rising edge), MEAS (counting).
REQ-017 Level load with max>min SHALL move IDLE->ARM; level load with max<=min SHALL force IDLE from any state, clear sq and counters, and not emit period_vld.
REQ-018 Level load in ARM or MEAS with max>min SHALL update thresholds without changing state or counters.
REQ-019 sq SHALL be registered (latency 1): set when data_u>th_hi, cleared when data_u<th_lo, otherwise held; held at 0 in IDLE.
REQ-020 Rising edge = sq 1 with previous sq 0; comparisons in the cycle of a level load use the old thresholds.
REQ-021 ARM: rising edge sets cnt<=1, edge_cnt<=0, state MEAS; otherwise cnt increments each cycle.
REQ-022 MEAS: cnt increments each cycle; rising edge increments edge_cnt; so for period P, cnt equals P at the next edge.
REQ-023 On the 2^LOG2_PERIODS-th edge in MEAS: period<=cnt>>LOG2_PERIODS (truncating), period_vld=1 for one cycle, timeout<=0, cnt<=1, edge_cnt<=0, remain MEAS.
REQ-024 If cnt reaches TIMEOUT in ARM or MEAS before a result: period<=0, timeout<=1, period_vld pulse, cnt<=0, state ARM.
REQ-025 If timeout and a result coincide, the result SHALL take priority.
REQ-026 cnt SHALL saturate at 2^32-1 and never wrap.

Reset
REQ-027 rst high at a clock edge SHALL set state IDLE, sq=0, period=0, period_vld=0, timeout=0, cnt=0, edge_cnt=0, thresholds=0, and the lvl_upd edge register=0.
REQ-028 Reset mid-measurement SHALL discard partial counts; the next result requires a fresh level load and arming edge.

Configuration
REQ-029 Macro TRIG_PERIOD_HYST_EN defined: hysteresis per REQ-015.
REQ-030 Macro TRIG_PERIOD_HYST_EN undefined: hyst=0, so th_hi=th_lo=mid; sq sets on data_u>mid and clears on data_u<mid; no hysteresis logic is synthesised.

Verification
REQ-031 Reset: assert rst 2 cycles -> all outputs 0, no period_vld until a level load.
REQ-032 Square 0/4000 with period 100, max=4000, min=0, vpp=4000, pulse lvl_upd -> th_hi=2500, th_lo=1500; period=100 with period_vld 400 cycles after the arming edge, then every 400 cycles.
REQ-033 With HYST_EN, sine 0..4000 with period 50 and ±200 noise at the crossings -> period=50 every result, no extra sq edges; without HYST_EN -> sq glitches are observable.
REQ-034 Level load with max=min=1000 during MEAS -> state IDLE, sq=0, no period_vld for 10000 cycles.
REQ-035 After arming, hold data_u=3000 -> after 4096 cycles: period_vld, period=0, timeout=1; resume the square wave -> next result clears timeout.
REQ-036 max=4095, min=3800, vpp=2000 -> th_hi saturates to 4095, th_lo=3697; no wrap-around.
